// File: rtl/nbit_seq_alu.sv
// Two-stage valid/ready ALU: add/sub/logic/rotate/negate with {Carry, Ovf, Zero, Neg} flags.
// Define NBIT_SEQ_ALU_ACC_EN to add AccSel, which swaps A for the last transferred result.
module nbit_seq_alu #(
   parameter int Width = 8,
   parameter int AmtW  = $clog2(Width)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [2:0]       Sel,
   input  logic [Width-1:0] A,
   input  logic [Width-1:0] B,
   input  logic             CIn,
   input  logic [AmtW-1:0]  RotAmt,
`ifdef NBIT_SEQ_ALU_ACC_EN
   input  logic             AccSel,
`endif
   output logic             OutValid,
   input  logic             OutReady,
   output logic [Width-1:0] Out,
   output logic [3:0]       Flags
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_ROL  = 3'b101,
      OP_ROR  = 3'b110,
      OP_TWOS = 3'b111
   } op_e;

   logic             r_s1_valid;
   op_e              r_op;
   logic [Width-1:0] r_a;
   logic [Width-1:0] r_b;
   logic             r_cin;
   logic [AmtW-1:0]  r_rot;
   logic             r_s2_valid;
   logic [Width-1:0] r_out;
   logic [3:0]       r_flags;

   logic               w_s2_adv;
   logic [Width-1:0]   w_a;
   logic [Width:0]     w_add;
   logic [Width:0]     w_sub;
   logic [AmtW-1:0]    w_rot_n;
   logic [2*Width-1:0] w_rol;
   logic [2*Width-1:0] w_ror;
   logic [Width-1:0]   w_res;
   logic               w_carry;
   logic               w_ovf;

   // Stage 2 may load when empty or draining; stage 1 may load when stage 2 moves or stage 1 is empty.
   assign w_s2_adv = !r_s2_valid || OutReady;
   assign InReady  = w_s2_adv || !r_s1_valid;
   assign OutValid = r_s2_valid;
   assign Out      = r_out;
   assign Flags    = r_flags;

`ifdef NBIT_SEQ_ALU_ACC_EN
   logic             r_acc_sel;
   logic [Width-1:0] r_acc;
   logic [Width-1:0] w_acc_fwd;

   // A result leaving on this edge is already the most recent one, so forward it.
   assign w_acc_fwd = (r_s2_valid && OutReady) ? r_out : r_acc;
   assign w_a       = r_acc_sel ? w_acc_fwd : r_a;
`else
   assign w_a = r_a;
`endif

   assign w_add   = {1'b0, w_a} + {1'b0, r_b} + {{Width{1'b0}}, r_cin};
   assign w_sub   = {1'b0, w_a} - {1'b0, r_b} - {{Width{1'b0}}, r_cin};
   assign w_rot_n = AmtW'(int'(r_rot) % Width);
   assign w_rol   = {w_a, w_a} << w_rot_n;
   assign w_ror   = {w_a, w_a} >> w_rot_n;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res   = w_add[Width-1:0];
            w_carry = w_add[Width];
            w_ovf   = (w_a[Width-1] == r_b[Width-1]) && (w_res[Width-1] != w_a[Width-1]);
         end
         OP_SUB: begin
            w_res   = w_sub[Width-1:0];
            w_carry = w_sub[Width];
            w_ovf   = (w_a[Width-1] != r_b[Width-1]) && (w_res[Width-1] != w_a[Width-1]);
         end
         OP_AND: w_res = w_a & r_b;
         OP_OR:  w_res = w_a | r_b;
         OP_XOR: w_res = w_a ^ r_b;
         OP_ROL: begin
            w_res   = w_rol[2*Width-1:Width];
            w_carry = (w_rot_n != '0) && w_res[0];
         end
         OP_ROR: begin
            w_res   = w_ror[Width-1:0];
            w_carry = (w_rot_n != '0) && w_res[Width-1];
         end
         OP_TWOS: begin
            w_res   = '0 - w_a;
            w_carry = (w_a == '0);
            w_ovf   = (w_a == {1'b1, {(Width-1){1'b0}}});
         end
      endcase
   end

   // NOTE: non-blocking assignments so both stages sample pre-edge values and shift in lockstep.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_out      <= '0;
         r_flags    <= '0;
`ifdef NBIT_SEQ_ALU_ACC_EN
         r_acc      <= '0;
`endif
      end else begin
         if (InReady) r_s1_valid <= InValid;
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out   <= w_res;
               r_flags <= {w_carry, w_ovf, (w_res == '0), w_res[Width-1]};
            end
         end
`ifdef NBIT_SEQ_ALU_ACC_EN
         if (r_s2_valid && OutReady) r_acc <= r_out;
`endif
      end
   end

   // NOTE: stage-1 payload has no reset; r_s1_valid alone decides whether it is meaningful.
   always_ff @(posedge Clk) begin
      if (InReady && InValid) begin
         r_op  <= op_e'(Sel);
         r_a   <= A;
         r_b   <= B;
         r_cin <= CIn;
         r_rot <= RotAmt;
`ifdef NBIT_SEQ_ALU_ACC_EN
         r_acc_sel <= AccSel;
`endif
      end
   end

endmodule

// File: tb/tb_nbit_seq_alu.sv
// Self-checking bench for nbit_seq_alu (Width = 8): a scoreboard of expected beats from an
// arithmetic model, checked on every output transfer, plus directed literal vectors.
module tb_nbit_seq_alu;
   localparam int W = 8;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ANDO = 3'b010, ORO = 3'b011,
                          XORO = 3'b100, ROL = 3'b101, ROR = 3'b110, TWOS = 3'b111;

   logic         Clk = 1'b0;
   logic         Reset, InValid, InReady, CIn, OutValid, OutReady;
   logic [2:0]   Sel;
   logic [W-1:0] A, B, Out;
   logic [2:0]   RotAmt;
   logic [3:0]   Flags;
`ifdef NBIT_SEQ_ALU_ACC_EN
   logic         AccSel;
`endif

   int          checks = 0;
   int          errors = 0;
   int          n_out  = 0;
   int          last_wait = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  model_acc = '0;
   logic        acc_sel_tb = 1'b0;
   logic        prev_stall = 1'b0;
   logic [11:0] prev_beat;
   logic [11:0] e;

   nbit_seq_alu #(.Width(W)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .Sel(Sel),
      .A(A), .B(B), .CIn(CIn), .RotAmt(RotAmt),
`ifdef NBIT_SEQ_ALU_ACC_EN
      .AccSel(AccSel),
`endif
      .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .Flags(Flags)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Result packed as {Carry, Ovf, Zero, Neg, Out[7:0]}.
   function automatic logic [11:0] model(input logic [2:0] sel, input logic [7:0] a, b,
                                         input logic cin, input int rot);
      int ua, ub, sa, sb, r, n, s;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      n  = rot % 8;
      c  = 1'b0;
      v  = 1'b0;
      r  = 0;
      case (sel)
         ADD: begin
            r = ua + ub + int'(cin);
            s = sa + sb + int'(cin);
            c = (r > 255);
            v = (s > 127) || (s < -128);
         end
         SUB: begin
            r = ua - ub - int'(cin);
            s = sa - sb - int'(cin);
            c = (r < 0);
            v = (s > 127) || (s < -128);
         end
         ANDO: r = ua & ub;
         ORO:  r = ua | ub;
         XORO: r = ua ^ ub;
         ROL: begin
            r = (ua << n) | (ua >> (8 - n));
            c = (n != 0) && (((ua >> (8 - n)) & 1) == 1);
         end
         ROR: begin
            r = (ua >> n) | (ua << (8 - n));
            c = (n != 0) && (((ua >> (n - 1)) & 1) == 1);
         end
         default: begin
            r = 256 - ua;
            c = (ua == 0);
            v = (ua == 128);
         end
      endcase
      r = r & 255;
      return {c, v, (r == 0), (r >= 128), 8'(r)};
   endfunction

   // Drive one beat, wait (bounded) for acceptance, then record the expected result.
   task automatic drive(input logic [2:0] sel, input logic [7:0] a, b, input logic cin, input int rot);
      logic ok;
      int   budget;
      budget = 0;
      ok = 1'b0;
      Sel = sel; A = a; B = b; CIn = cin; RotAmt = 3'(rot); InValid = 1'b1;
`ifdef NBIT_SEQ_ALU_ACC_EN
      AccSel = acc_sel_tb;
`endif
      while (!ok && budget <= 50) begin
         @(negedge Clk);
         ok = InReady;
         @(posedge Clk);
         if (!ok) budget++;
      end
      last_wait = budget;
      if (!ok) check("in_ready_timeout", 32'(ok), 1);
      else exp_q.push_back(model(sel, acc_sel_tb ? model_acc : a, b, cin, rot));
      #1 InValid = 1'b0;
   endtask

   task automatic drive_lit(input string name, input logic [2:0] sel, input logic [7:0] a, b,
                            input logic cin, input int rot, input logic [11:0] lit);
      check({"model_", name}, model(sel, a, b, cin, rot), lit);
      drive(sel, a, b, cin, rot);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || OutValid) && budget < 60) begin
         @(negedge Clk);
         budget++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard: every transfer must match the oldest expected beat; stalls must hold the beat.
   always @(negedge Clk) begin
      if (Reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold_valid", OutValid, 1);
            check("stall_hold_beat", {Flags, Out}, prev_beat);
         end
         if (OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", OutValid, 0);
            end else begin
               e = exp_q.pop_front();
               check("result", {Flags, Out}, e);
               model_acc = e[7:0];
               n_out++;
            end
         end
         prev_stall = OutValid && !OutReady;
         prev_beat  = {Flags, Out};
      end
   end

   initial begin
      int n_before;
      Reset = 1'b1; InValid = 1'b0; Sel = '0; A = '0; B = '0; CIn = 1'b0; RotAmt = '0;
      OutReady = 1'b1;
`ifdef NBIT_SEQ_ALU_ACC_EN
      AccSel = 1'b0;
`endif
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      check("rst_out_valid", OutValid, 0);
      check("rst_out", Out, 0);
      check("rst_flags", Flags, 0);
      check("rst_in_ready", InReady, 1);

      // First beat: result appears exactly two edges after acceptance.
      @(posedge Clk);
      #1;
      drive_lit("add_ff_01", ADD, 8'hFF, 8'h01, 1'b0, 0, 12'hA00);
      @(negedge Clk);
      check("latency_not_early", OutValid, 0);
      @(negedge Clk);
      check("latency_two", OutValid, 1);
      check("add_ff_01_out", Out, 8'h00);
      check("add_ff_01_flags", Flags, 4'b1010);
      wait_drain();

      // Back-to-back directed vectors; each must be accepted without waiting.
      drive_lit("sub_80_01", SUB, 8'h80, 8'h01, 1'b0, 0, 12'h47F);
      drive_lit("twos_80", TWOS, 8'h80, 8'h33, 1'b0, 0, 12'h580);
      check("sustain_rate", last_wait, 0);
      drive_lit("rol_81_1", ROL, 8'h81, 8'hFF, 1'b0, 1, 12'h803);
      drive_lit("ror_81_9", ROR, 8'h81, 8'h00, 1'b0, 9, 12'h9C0);
      check("sustain_rate", last_wait, 0);
      drive_lit("rol_81_0", ROL, 8'h81, 8'h00, 1'b0, 0, 12'h181);
      drive_lit("sub_borrow", SUB, 8'h05, 8'h05, 1'b1, 0, 12'h9FF);
      drive_lit("add_ovf", ADD, 8'h7F, 8'h01, 1'b0, 0, 12'h580);
      drive_lit("add_cin", ADD, 8'h01, 8'h01, 1'b1, 0, 12'h003);
      drive_lit("and_op", ANDO, 8'hF0, 8'h3C, 1'b1, 5, 12'h030);
      drive_lit("or_op", ORO, 8'hF0, 8'h0F, 1'b0, 0, 12'h1FF);
      drive_lit("xor_zero", XORO, 8'hAA, 8'hAA, 1'b0, 0, 12'h200);
      drive_lit("twos_00", TWOS, 8'h00, 8'h5A, 1'b1, 0, 12'hA00);
      check("sustain_rate", last_wait, 0);
      wait_drain();

      // Eight back-to-back beats with the sink stalled for three edges.
      n_before = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               drive(3'(i), 8'(i * 29 + 7), 8'(i * 53 + 200), 1'(i), i + 1);
         end
         begin
            repeat (2) @(posedge Clk);
            #1 OutReady = 1'b0;
            @(negedge Clk);
            check("in_ready_low_full", InReady, 0);
            check("out_valid_when_full", OutValid, 1);
            repeat (3) @(posedge Clk);
            #1 OutReady = 1'b1;
         end
      join
      wait_drain();
      check("stall_all_8_out", n_out - n_before, 8);

      // Reset with two beats in flight and a third offered during reset.
      drive(ADD, 8'h11, 8'h22, 1'b0, 0);
      drive(SUB, 8'h40, 8'h01, 1'b0, 0);
      Reset = 1'b1;
      exp_q.delete();
      model_acc = '0;
      Sel = XORO; A = 8'h5A; B = 8'hFF; InValid = 1'b1;
      n_before = n_out;
      @(posedge Clk);
      #1 Reset = 1'b0;
      InValid = 1'b0;
      @(negedge Clk);
      check("mid_rst_out_valid", OutValid, 0);
      check("mid_rst_out", Out, 0);
      check("mid_rst_flags", Flags, 0);
      check("mid_rst_in_ready", InReady, 1);
      repeat (6) @(negedge Clk);
      check("mid_rst_no_stale", n_out - n_before, 0);
      @(posedge Clk);
      #1;

      // Mixed opcodes under an irregular sink-ready pattern.
      fork
         begin
            for (int i = 0; i < 24; i++)
               drive(3'(i % 8), 8'(i * 37 + 5), 8'(i * 91 + 3), 1'(i / 3), i % 11);
         end
         begin
            for (int c = 0; c < 40; c++) begin
               OutReady = ((c % 3) != 1);
               @(posedge Clk);
               #1;
            end
            OutReady = 1'b1;
         end
      join
      OutReady = 1'b1;
      wait_drain();

`ifdef NBIT_SEQ_ALU_ACC_EN
      drive_lit("acc_first", ADD, 8'h05, 8'h03, 1'b0, 0, 12'h008);
      wait_drain();
      acc_sel_tb = 1'b1;
      check("acc_model_pin", model(ADD, model_acc, 8'h02, 1'b0, 0), 12'h00A);
      drive(ADD, 8'h77, 8'h02, 1'b0, 0);
      wait_drain();
      check("acc_result", model_acc, 8'h0A);
      acc_sel_tb = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
